// File: rtl/hazard_scoreboard.sv
// In-order issue hazard scoreboard: a per-register countdown of cycles until a
// pending result is forwardable, producing RAW/WAW stall, bubble and PC/IF-ID enables.
module hsRegCnt #(
  parameter int LATW = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic [LATW-1:0] loadVal,
  output logic [LATW-1:0] cnt
);
  // A fresh issue takes priority over the running countdown.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)            cnt <= '0;
    else if (load)        cnt <= loadVal;
    else if (cnt != '0)   cnt <= cnt - LATW'(1);
  end
endmodule

module hazard_scoreboard #(
  parameter int NREG    = 32,
  parameter int MAX_LAT = 4,
  parameter int CNTW    = 16,
  localparam int REGW   = $clog2(NREG),
  localparam int LATW   = $clog2(MAX_LAT + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  input  logic [REGW-1:0] id_dst,
  input  logic            id_wr,
  input  logic [LATW-1:0] id_lat,
  input  logic            flush,
  output logic            stall,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            ctrl_bubble,
  output logic            pending,
  output logic [CNTW-1:0] stall_count
);
  localparam int NSLOT = 2 ** REGW;
  localparam logic [LATW-1:0] MaxLat = LATW'(MAX_LAT);

  logic [NSLOT-1:0][LATW-1:0] cntAll;
  logic [LATW-1:0] effLat, cntRs, cntRt, cntDst;
  logic            rawHaz, wawHaz, issue;

  always_comb begin
    effLat = id_lat;
    if (id_lat == '0)         effLat = LATW'(1);
    else if (id_lat > MaxLat) effLat = MaxLat;
  end

  // Slot 0 and any slot past NREG-1 read as permanently idle.
  assign cntAll[0] = '0;
  for (genvar r = 1; r < NSLOT; r++) begin : gReg
    if (r < NREG) begin : gLive
      hsRegCnt #(.LATW(LATW)) uCnt (
        .clock   (clock),
        .reset   (reset),
        .load    (issue && (id_dst == REGW'(r))),
        .loadVal (effLat),
        .cnt     (cntAll[r])
      );
    end else begin : gNone
      assign cntAll[r] = '0;
    end
  end

  assign cntRs  = cntAll[id_rs];
  assign cntRt  = cntAll[id_rt];
  assign cntDst = cntAll[id_dst];

  // cnt==1 means the value is forwardable next cycle, so only >1 stalls a reader.
  assign rawHaz = id_valid &
                  ((id_uses_rs & (id_rs != '0) & (cntRs > LATW'(1))) |
                   (id_uses_rt & (id_rt != '0) & (cntRt > LATW'(1))));
  assign wawHaz = id_valid & id_wr & (id_dst != '0) & (cntDst > effLat);

  assign stall       = (rawHaz | wawHaz) & ~flush & ~reset;
  assign pc_write    = ~stall;
  assign ifid_write  = ~stall;
  assign ctrl_bubble = stall | flush;
  assign pending     = |cntAll;
  assign issue       = id_valid & ~stall & ~flush & id_wr & (id_dst != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                           stall_count <= '0;
    else if (stall && stall_count != '1) stall_count <= stall_count + CNTW'(1);
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed check of hazard_scoreboard against a per-register
// countdown model; narrow stall counter so saturation is reached.
module tb_hazard_scoreboard;
  localparam int NREG = 32, MAX_LAT = 4, CNTW = 4, REGW = 5, LATW = 3;
  localparam int CMAX = (1 << CNTW) - 1;

  logic clock = 1'b0, reset = 1'b1;
  logic id_valid, id_uses_rs, id_uses_rt, id_wr, flush;
  logic [REGW-1:0] id_rs, id_rt, id_dst;
  logic [LATW-1:0] id_lat;
  logic stall, pc_write, ifid_write, ctrl_bubble, pending;
  logic [CNTW-1:0] stall_count;

  hazard_scoreboard #(.NREG(NREG), .MAX_LAT(MAX_LAT), .CNTW(CNTW)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst), .id_wr(id_wr),
    .id_lat(id_lat), .flush(flush), .stall(stall), .pc_write(pc_write),
    .ifid_write(ifid_write), .ctrl_bubble(ctrl_bubble), .pending(pending),
    .stall_count(stall_count));

  always #5 clock = ~clock;

  int nVec = 0, nErr = 0;
  int refCnt[NREG];
  int refStalls;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int effLat(input int l);
    if (l == 0) return 1;
    if (l > MAX_LAT) return MAX_LAT;
    return l;
  endfunction

  task automatic setIn(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                       input int dst, input bit wr, input int lat, input bit fl);
    id_valid = v; id_rs = REGW'(rs); id_uses_rs = urs; id_rt = REGW'(rt); id_uses_rt = urt;
    id_dst = REGW'(dst); id_wr = wr; id_lat = LATW'(lat); flush = fl;
  endtask

  task automatic clrModel();
    foreach (refCnt[r]) refCnt[r] = 0;
    refStalls = 0;
  endtask

  // Called at a falling edge with inputs applied; checks, then advances one cycle.
  task automatic cycle(input int expStall);
    bit raw, waw, st, pend;
    #1;
    raw = id_valid && ((id_uses_rs && id_rs != 0 && refCnt[id_rs] > 1) ||
                       (id_uses_rt && id_rt != 0 && refCnt[id_rt] > 1));
    waw = id_valid && id_wr && id_dst != 0 && refCnt[id_dst] > effLat(int'(id_lat));
    st  = (raw || waw) && !flush;
    pend = 0;
    foreach (refCnt[r]) if (refCnt[r] != 0) pend = 1;
    chk("stall", stall, st);
    if (expStall >= 0) chk("stallDirected", stall, expStall);
    chk("pc_write", pc_write, !st);
    chk("ifid_write", ifid_write, !st);
    chk("ctrl_bubble", ctrl_bubble, st || flush);
    chk("pending", pending, pend);
    chk("stall_count", stall_count, refStalls);
    @(posedge clock);
    foreach (refCnt[r]) if (refCnt[r] > 0) refCnt[r]--;
    if (id_valid && !st && !flush && id_wr && id_dst != 0) refCnt[id_dst] = effLat(int'(id_lat));
    if (st && refStalls < CMAX) refStalls++;
    @(negedge clock);
  endtask

  task automatic doReset();
    reset = 1'b1;
    setIn(0, 0, 0, 0, 0, 0, 0, 1, 0);
    clrModel();
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    setIn(0, 0, 0, 0, 0, 0, 0, 1, 1);
    clrModel();
    #2;
    chk("rstStall", stall, 0);
    chk("rstPcWrite", pc_write, 1);
    chk("rstIfidWrite", ifid_write, 1);
    chk("rstBubbleFlush", ctrl_bubble, 1);
    chk("rstPending", pending, 0);
    chk("rstCount", stall_count, 0);
    doReset();

    // ALU producer then dependent: no bubble
    setIn(1, 0, 0, 0, 0, 5, 1, 1, 0); cycle(0);
    setIn(1, 5, 1, 0, 0, 0, 0, 1, 0); cycle(0);
    chk("lat1Count", stall_count, 0);

    // load producer then dependent on rt: one bubble
    doReset();
    setIn(1, 0, 0, 0, 0, 8, 1, 2, 0); cycle(0);
    setIn(1, 0, 0, 8, 1, 0, 0, 1, 0); cycle(1); cycle(0);
    chk("lat2Count", stall_count, 1);

    // latency 4 producer: three bubbles, pending through the countdown
    doReset();
    setIn(1, 0, 0, 0, 0, 3, 1, 4, 0); cycle(0);
    setIn(1, 3, 1, 0, 0, 0, 0, 1, 0); cycle(1); cycle(1); cycle(1); cycle(0);
    chk("lat4Count", stall_count, 3);
    setIn(0, 0, 0, 0, 0, 0, 0, 1, 0); cycle(0);
    chk("lat4Drained", pending, 0);

    // WAW: slow write then fast write to same register
    doReset();
    setIn(1, 0, 0, 0, 0, 7, 1, 4, 0); cycle(0);
    setIn(1, 0, 0, 0, 0, 7, 1, 1, 0); cycle(1); cycle(1); cycle(1); cycle(0);
    chk("wawPending", pending, 1);
    setIn(1, 7, 1, 0, 0, 0, 0, 1, 0); cycle(0);

    // r0 never tracked; flushed instruction neither stalls nor loads
    doReset();
    setIn(1, 0, 0, 0, 0, 0, 1, 4, 0); cycle(0);
    setIn(1, 0, 1, 0, 1, 0, 0, 1, 0); cycle(0);
    chk("r0Pending", pending, 0);
    setIn(1, 0, 0, 0, 0, 9, 1, 4, 0); cycle(0);
    setIn(1, 9, 1, 0, 0, 10, 1, 4, 1); cycle(0);
    setIn(1, 10, 1, 0, 0, 0, 0, 1, 0); cycle(0);

    // reset asserted in the middle of a stall
    doReset();
    setIn(1, 0, 0, 0, 0, 3, 1, 4, 0); cycle(0);
    setIn(1, 3, 1, 0, 0, 0, 0, 1, 0); cycle(1);
    chk("preRstStall", stall, 1);
    #1 reset = 1'b1;
    #1;
    chk("midRstStall", stall, 0);
    chk("midRstPending", pending, 0);
    chk("midRstCount", stall_count, 0);
    chk("midRstPcWrite", pc_write, 1);
    clrModel();
    @(negedge clock);
    reset = 1'b0;
    cycle(0);

    // randomized traffic, small register window for dense hazards
    doReset();
    repeat (600) begin
      setIn($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 9) == 0);
      cycle(-1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
